// File: rtl/inst_fetch_responder_if.sv
// Instruction fetch request/response bus plus memory preload port.
// The slave modport is the responder; the master modport is the fetch
// unit (or loader) driving requests and consuming responses.
interface inst_fetch_responder_if #(
  parameter int unsigned DEPTH_LOG2 = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic [63:0]           req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_inst;
  logic [63:0]           resp_addr;
  logic                  resp_err;
  logic                  ld_en;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [31:0]           ld_data;

  modport master (
    output req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, resp_valid, resp_inst, resp_addr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
    output req_ready, resp_valid, resp_inst, resp_addr, resp_err
  );
endinterface

// File: rtl/inst_fetch_responder.sv
// Instruction fetch responder: a synchronous-read instruction memory behind
// a one-entry request stage and a two-entry response FIFO. Out-of-range or
// misaligned PCs return a fault response with a zero instruction word.
module inst_fetch_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inst_fetch_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];

  logic [61:0]           off_w;
  logic [DEPTH_LOG2-1:0] widx;
  logic                  req_err;
  logic                  accept;

  logic                  s1_valid;
  logic [63:0]           s1_addr;
  logic                  s1_err;
  logic [31:0]           rd_data;

  logic [31:0]           f_inst [2];
  logic [63:0]           f_addr [2];
  logic                  f_err  [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;
  logic                  push;
  logic                  pop;

  // Word offset from the base; wrapping subtraction makes addresses below
  // the base land far out of range, so a single upper-bits test covers both.
  assign off_w   = 62'((bus.req_addr - BASE_ADDR) >> 2);
  assign widx    = off_w[DEPTH_LOG2-1:0];
  assign req_err = (bus.req_addr[1:0] != 2'b00) || ((off_w >> DEPTH_LOG2) != '0);

  // At most one entry in stage 1 plus FIFO whenever a new request is taken,
  // so the two FIFO slots can always absorb the stage-1 push.
  assign bus.req_ready = (2'(fifo_count + 2'(s1_valid)) <= 2'd1);
  assign accept        = bus.req_valid && bus.req_ready;

  assign push = s1_valid;
  assign pop  = bus.resp_valid && bus.resp_ready;

  assign bus.resp_valid = (fifo_count != 2'd0);
  assign bus.resp_inst  = bus.resp_valid ? f_inst[rd_ptr] : '0;
  assign bus.resp_addr  = bus.resp_valid ? f_addr[rd_ptr] : '0;
  assign bus.resp_err   = bus.resp_valid ? f_err[rd_ptr]  : 1'b0;

  // Instruction memory: preload write and fetch read; the read samples the
  // old contents when both target the same word. Not reset.
  always_ff @(posedge clk) begin
    if (bus.ld_en)
      mem[bus.ld_addr] <= bus.ld_data;
    if (accept)
      rd_data <= mem[widx];
  end

  // Stage-1 request register: valid flag plus echoed address and fault bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= bus.req_addr;
        s1_err  <= req_err;
      end
    end
  end

  // Response FIFO storage; faulting entries carry a zero instruction word.
  always_ff @(posedge clk) begin
    if (push) begin
      f_inst[wr_ptr] <= s1_err ? 32'h0 : rd_data;
      f_addr[wr_ptr] <= s1_addr;
      f_err[wr_ptr]  <= s1_err;
    end
  end

  // Response FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: table of single fetches plus
// hand-written sequences for backpressure, streaming, read-before-write
// and mid-operation reset.
module tb_inst_fetch_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
  localparam int unsigned DL2  = 10;

  logic clk;
  logic rst_n;
  int   ntests;
  int   nfail;

  inst_fetch_responder_if #(.DEPTH_LOG2(DL2)) bus ();

  inst_fetch_responder #(
    .BASE_ADDR (BASE),
    .DEPTH_LOG2(DL2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int unsigned k);
    if (k == 0)      return 32'h0010_0093;
    else if (k == 1) return 32'h0020_8113;
    else             return 32'hA000_0000 | k;
  endfunction

  // Single fetch with resp_ready=1: accept on the next edge, response
  // visible after the following edge, popped on the one after.
  task automatic fetch(input string nm, input logic [63:0] a,
                       input logic [31:0] ei, input logic ee);
    bus.req_valid  = 1'b1;
    bus.req_addr   = a;
    bus.resp_ready = 1'b1;
    chk({nm, "_rdy"}, 64'(bus.req_ready), 64'd1);
    tick;
    bus.req_valid = 1'b0;
    bus.ld_en     = 1'b0;
    chk({nm, "_lat0"}, 64'(bus.resp_valid), 64'd0);
    tick;
    chk({nm, "_vld"},  64'(bus.resp_valid), 64'd1);
    chk({nm, "_inst"}, 64'(bus.resp_inst),  64'(ei));
    chk({nm, "_addr"}, bus.resp_addr,       a);
    chk({nm, "_err"},  64'(bus.resp_err),   64'(ee));
    tick;
    chk({nm, "_drain"}, 64'(bus.resp_valid), 64'd0);
  endtask

  vec_t vecs [10];

  initial begin
    ntests = 0;
    nfail  = 0;

    vecs[0] = '{64'h0000_0000_8000_0000, 32'h0010_0093, 1'b0};
    vecs[1] = '{64'h0000_0000_8000_0004, 32'h0020_8113, 1'b0};
    vecs[2] = '{64'h0000_0000_8000_0002, 32'h0000_0000, 1'b1};
    vecs[3] = '{64'h0000_0000_7FFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[4] = '{64'h0000_0000_8000_1000, 32'h0000_0000, 1'b1};
    vecs[5] = '{64'h0000_0000_8000_0FFC, 32'hCAFE_F00D, 1'b0};
    vecs[6] = '{64'h0000_0000_8000_0001, 32'h0000_0000, 1'b1};
    vecs[7] = '{64'h0000_0000_0000_0000, 32'h0000_0000, 1'b1};
    vecs[8] = '{64'h0000_0000_8000_0010, 32'hA000_0004, 1'b0};
    vecs[9] = '{64'hFFFF_FFFF_8000_0000, 32'h0000_0000, 1'b1};

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b0;
    bus.ld_en      = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;

    @(negedge clk);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_inst",  64'(bus.resp_inst),  64'd0);
    chk("rst_resp_addr",  bus.resp_addr,       64'd0);
    chk("rst_resp_err",   64'(bus.resp_err),   64'd0);
    rst_n = 1'b1;
    chk("post_rst_ready", 64'(bus.req_ready), 64'd1);

    // Preload words 0..15 and the top word.
    for (int k = 0; k < 16; k++) begin
      bus.ld_en   = 1'b1;
      bus.ld_addr = DL2'(k);
      bus.ld_data = exp_word(k);
      tick;
    end
    bus.ld_en   = 1'b1;
    bus.ld_addr = '1;
    bus.ld_data = 32'hCAFE_F00D;
    tick;
    bus.ld_en = 1'b0;

    for (int i = 0; i < 10; i++)
      fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].inst, vecs[i].err);

    // Backpressure: two accepts with resp_ready low, then drain in order.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = BASE;
    tick;
    bus.req_addr = BASE + 64'd4;
    chk("bp_rdy2", 64'(bus.req_ready), 64'd1);
    tick;
    chk("bp_rdy_drop", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 1'b0;
    tick;
    chk("bp_vld",   64'(bus.resp_valid), 64'd1);
    chk("bp_inst0", 64'(bus.resp_inst),  64'h0010_0093);
    for (int h = 0; h < 3; h++) begin
      tick;
      chk("bp_hold_inst", 64'(bus.resp_inst), 64'h0010_0093);
      chk("bp_hold_addr", bus.resp_addr,      BASE);
      chk("bp_hold_rdy",  64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    tick;
    chk("bp_vld1",  64'(bus.resp_valid), 64'd1);
    chk("bp_inst1", 64'(bus.resp_inst),  64'h0020_8113);
    chk("bp_addr1", bus.resp_addr,       BASE + 64'd4);
    tick;
    chk("bp_empty", 64'(bus.resp_valid), 64'd0);

    // Stream of 16 sequential PCs with the consumer always ready.
    begin
      int   sent;
      int   got;
      int   cyc;
      logic acc;
      sent = 0;
      got  = 0;
      cyc  = 0;
      bus.resp_ready = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_addr   = BASE;
      while (got < 16 && cyc < 200) begin
        if (bus.resp_valid) begin
          chk($sformatf("st%0d_addr", got), bus.resp_addr, BASE + 64'(4 * got));
          chk($sformatf("st%0d_inst", got), 64'(bus.resp_inst), 64'(exp_word(got)));
          chk($sformatf("st%0d_err", got),  64'(bus.resp_err), 64'd0);
          got++;
        end
        acc = bus.req_valid && bus.req_ready;
        tick;
        cyc++;
        if (acc) begin
          sent++;
          if (sent < 16) bus.req_addr = BASE + 64'(4 * sent);
          else           bus.req_valid = 1'b0;
        end
      end
      chk("stream_count", 64'(got), 64'd16);
      chk("stream_cycles_bound", 64'(cyc <= 40), 64'd1);
      chk("stream_no_extra", 64'(bus.resp_valid), 64'd0);
    end

    // Preload write to the word being fetched in the same cycle.
    bus.ld_en   = 1'b1;
    bus.ld_addr = DL2'(2);
    bus.ld_data = 32'hDEAD_BEEF;
    fetch("rbw_old", BASE + 64'd8, 32'hA000_0002, 1'b0);
    fetch("rbw_new", BASE + 64'd8, 32'hDEAD_BEEF, 1'b0);

    // Reset with two buffered responses.
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = BASE;
    tick;
    bus.req_addr = BASE + 64'd4;
    tick;
    bus.req_valid = 1'b0;
    tick;
    chk("mr_pre_vld", 64'(bus.resp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_vld",  64'(bus.resp_valid), 64'd0);
    chk("mr_inst", 64'(bus.resp_inst),  64'd0);
    chk("mr_addr", bus.resp_addr,       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_ready", 64'(bus.req_ready), 64'd1);
    tick;
    chk("mr_still_empty", 64'(bus.resp_valid), 64'd0);
    fetch("mr_mem0", BASE, 32'h0010_0093, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
